// File: rtl/spi_xfer_sequencer.sv
// Command-then-read transaction sequencer in front of an SPI byte engine.
// Optional done-flag watchdog enabled by defining SEQ_TIMEOUT_EN.
module spi_xfer_sequencer #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_start,
    input  logic [7:0] I_cmd,
    input  logic [3:0] I_rd_cnt,
    output logic       O_busy,
    output logic [7:0] O_rd_data,
    output logic       O_rd_valid,
    output logic       O_done,
    output logic       O_err,
    output logic       O_tx_en,
    output logic       O_rx_en,
    output logic [7:0] O_tx_byte,
    input  logic       I_tx_done,
    input  logic       I_rx_done,
    input  logic [7:0] I_rx_byte
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_CMD_TAIL,
        S_GAP,
        S_RD,
        S_FINISH
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          tx_en_q, tx_en_d;
    logic          rx_en_q, rx_en_d;
    logic          timeout;

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;

    // Cleared on every state entry, so each byte gets a fresh budget.
    always_comb begin
        wd_d = 8'd0;
        if (state_d == state_q && (state_q == S_CMD || state_q == S_RD)) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout = (wd_q == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (I_start) begin
                    cmd_d   = I_cmd;
                    cnt_d   = I_rd_cnt;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (I_tx_done) begin
                    state_d = S_CMD_TAIL;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_CMD_TAIL: begin
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = (cnt_q == 4'd0) ? S_FINISH : S_RD;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_RD: begin
                // Engine clears its data once rx_en drops, so grab it now.
                if (I_rx_done) begin
                    rd_data_d  = I_rx_byte;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                    gap_d      = GAP_LOAD;
                    state_d    = S_GAP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d  = (state_d == S_FINISH);
        tx_en_d = (state_d == S_CMD) || (state_d == S_CMD_TAIL);
        rx_en_d = (state_d == S_RD);
        busy_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= 8'd0;
            cnt_q      <= 4'd0;
            gap_q      <= '0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
        end
    end

    assign O_busy     = busy_q;
    assign O_rd_data  = rd_data_q;
    assign O_rd_valid = rd_valid_q;
    assign O_done     = done_q;
    assign O_err      = err_q;
    assign O_tx_en    = tx_en_q;
    assign O_rx_en    = rx_en_q;
    assign O_tx_byte  = cmd_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer (GAP_CYCLES=2, TIMEOUT_CYCLES=64).
module tb_spi_xfer_sequencer;

    logic       I_clk = 1'b0;
    logic       I_rst = 1'b1;
    logic       I_start = 1'b0;
    logic [7:0] I_cmd = 8'd0;
    logic [3:0] I_rd_cnt = 4'd0;
    logic       O_busy;
    logic [7:0] O_rd_data;
    logic       O_rd_valid;
    logic       O_done;
    logic       O_err;
    logic       O_tx_en;
    logic       O_rx_en;
    logic [7:0] O_tx_byte;
    logic       I_tx_done = 1'b0;
    logic       I_rx_done = 1'b0;
    logic [7:0] I_rx_byte = 8'd0;

    int n_tests = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    bit rx_seen = 1'b0;
    bit mon_en = 1'b0;
    logic [7:0] exp_b [3] = '{8'h12, 8'h34, 8'h56};

    spi_xfer_sequencer #(
        .GAP_CYCLES(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .I_clk(I_clk),
        .I_rst(I_rst),
        .I_start(I_start),
        .I_cmd(I_cmd),
        .I_rd_cnt(I_rd_cnt),
        .O_busy(O_busy),
        .O_rd_data(O_rd_data),
        .O_rd_valid(O_rd_valid),
        .O_done(O_done),
        .O_err(O_err),
        .O_tx_en(O_tx_en),
        .O_rx_en(O_rx_en),
        .O_tx_byte(O_tx_byte),
        .I_tx_done(I_tx_done),
        .I_rx_done(I_rx_done),
        .I_rx_byte(I_rx_byte)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(O_busy), 0);
        chk({tag, "_txen"}, 32'(O_tx_en), 0);
        chk({tag, "_rxen"}, 32'(O_rx_en), 0);
        chk({tag, "_done"}, 32'(O_done), 0);
        chk({tag, "_err"}, 32'(O_err), 0);
        chk({tag, "_valid"}, 32'(O_rd_valid), 0);
        chk({tag, "_rdata"}, 32'(O_rd_data), 0);
        chk({tag, "_txbyte"}, 32'(O_tx_byte), 0);
    endtask

    always @(negedge I_clk) begin
        if (mon_en) begin
            chk("inv_txrx", 32'(O_tx_en & O_rx_en), 0);
            if (O_tx_en | O_rx_en) chk("inv_busy_en", 32'(O_busy), 1);
            if (O_done) chk("inv_busy_done", 32'(O_busy), 0);
            if (O_rd_valid) valid_cnt++;
            if (O_done) done_cnt++;
            if (O_rx_en) rx_seen = 1'b1;
        end
    end

    initial begin
        // power-on reset
        tick;
        tick;
        chk_zero("por");
        I_rst = 1'b0;
        mon_en = 1'b1;

        // cmd only, 0xA5
        I_cmd = 8'hA5;
        I_rd_cnt = 4'd0;
        I_start = 1'b1;
        tick;
        chk("t2_busy", 32'(O_busy), 1);
        chk("t2_txen", 32'(O_tx_en), 1);
        chk("t2_txbyte", 32'(O_tx_byte), 32'h A5);
        I_start = 1'b0;
        tick;
        tick;
        chk("t2_txen_wait", 32'(O_tx_en), 1);
        I_tx_done = 1'b1;
        tick;
        chk("t2_tail_txen", 32'(O_tx_en), 1);
        chk("t2_tail_byte", 32'(O_tx_byte), 32'h A5);
        I_tx_done = 1'b0;
        tick;
        chk("t2_gap_txen", 32'(O_tx_en), 0);
        chk("t2_gap_busy", 32'(O_busy), 1);
        tick;
        chk("t2_gap2_done", 32'(O_done), 0);
        tick;
        chk("t2_done", 32'(O_done), 1);
        chk("t2_done_busy", 32'(O_busy), 0);
        tick;
        chk("t2_done_pulse", 32'(O_done), 0);
        chk("t2_valid_cnt", 32'(valid_cnt), 0);
        chk("t2_done_cnt", 32'(done_cnt), 1);
        chk("t2_rx_seen", 32'(rx_seen), 0);

        // cmd 0x9F + three reads
        I_cmd = 8'h9F;
        I_rd_cnt = 4'd3;
        I_start = 1'b1;
        tick;
        chk("t3_txbyte", 32'(O_tx_byte), 32'h 9F);
        I_start = 1'b0;
        I_tx_done = 1'b1;
        tick;
        I_tx_done = 1'b0;
        tick;
        tick;
        tick;
        chk("t3_rd_rxen", 32'(O_rx_en), 1);
        chk("t3_rd_txen", 32'(O_tx_en), 0);
        for (int i = 0; i < 3; i++) begin
            I_rx_byte = exp_b[i];
            I_rx_done = 1'b1;
            tick;
            chk("t3_valid", 32'(O_rd_valid), 1);
            chk("t3_data", 32'(O_rd_data), 32'(exp_b[i]));
            chk("t3_gap1_rxen", 32'(O_rx_en), 0);
            I_rx_done = 1'b0;
            I_rx_byte = 8'hFF;
            if (i == 0) begin
                I_tx_done = 1'b1;
                I_rx_done = 1'b1;
                I_rx_byte = 8'hEE;
            end
            tick;
            chk("t3_gap2_valid", 32'(O_rd_valid), 0);
            chk("t3_gap2_en", 32'({O_tx_en, O_rx_en}), 0);
            I_tx_done = 1'b0;
            I_rx_done = 1'b0;
            I_rx_byte = 8'hFF;
            tick;
            if (i < 2) chk("t3_next_rd", 32'(O_rx_en), 1);
            else chk("t3_done", 32'(O_done), 1);
        end
        tick;
        chk("t3_valid_cnt", 32'(valid_cnt), 3);
        chk("t3_done_cnt", 32'(done_cnt), 2);

        // start held high, back-to-back
        I_start = 1'b1;
        I_cmd = 8'h3C;
        I_rd_cnt = 4'd1;
        tick;
        chk("t4_txen", 32'(O_tx_en), 1);
        chk("t4_txbyte", 32'(O_tx_byte), 32'h 3C);
        I_cmd = 8'hC3;
        I_tx_done = 1'b1;
        tick;
        chk("t4_tail_byte", 32'(O_tx_byte), 32'h 3C);
        I_tx_done = 1'b0;
        tick;
        tick;
        tick;
        chk("t4_rd", 32'(O_rx_en), 1);
        I_rx_byte = 8'h77;
        I_rx_done = 1'b1;
        tick;
        chk("t4_data", 32'(O_rd_data), 32'h 77);
        I_rx_done = 1'b0;
        tick;
        tick;
        chk("t4_done", 32'(O_done), 1);
        tick;
        chk("t4_idle_busy", 32'(O_busy), 0);
        chk("t4_idle_txen", 32'(O_tx_en), 0);
        tick;
        chk("t4_b2b_busy", 32'(O_busy), 1);
        chk("t4_b2b_txbyte", 32'(O_tx_byte), 32'h C3);
        I_start = 1'b0;
        I_tx_done = 1'b1;
        tick;
        I_tx_done = 1'b0;
        tick;
        tick;
        tick;
        I_rx_byte = 8'h88;
        I_rx_done = 1'b1;
        tick;
        chk("t4_data2", 32'(O_rd_data), 32'h 88);
        I_rx_done = 1'b0;
        tick;
        tick;
        chk("t4_done2", 32'(O_done), 1);
        tick;
        tick;
        chk("t4_no_restart", 32'(O_busy), 0);
        chk("t4_valid_cnt", 32'(valid_cnt), 5);
        chk("t4_done_cnt", 32'(done_cnt), 4);

        // reset held 3 cycles while in RD
        I_cmd = 8'h11;
        I_rd_cnt = 4'd2;
        I_start = 1'b1;
        tick;
        I_start = 1'b0;
        I_tx_done = 1'b1;
        tick;
        I_tx_done = 1'b0;
        tick;
        tick;
        tick;
        chk("t1_in_rd", 32'(O_rx_en), 1);
        I_rst = 1'b1;
        tick;
        chk_zero("t1_rst");
        tick;
        tick;
        I_rst = 1'b0;
        tick;
        chk("t1_post_busy", 32'(O_busy), 0);
        chk("t1_post_en", 32'({O_tx_en, O_rx_en}), 0);
        chk("t1_done_cnt", 32'(done_cnt), 4);
        chk("t1_valid_cnt", 32'(valid_cnt), 5);

`ifdef SEQ_TIMEOUT_EN
        I_cmd = 8'h22;
        I_rd_cnt = 4'd2;
        I_start = 1'b1;
        tick;
        I_start = 1'b0;
        I_tx_done = 1'b1;
        tick;
        I_tx_done = 1'b0;
        tick;
        tick;
        tick;
        chk("t6_rd", 32'(O_rx_en), 1);
        for (int i = 0; i < 63; i++) tick;
        chk("t6_rd64", 32'(O_rx_en), 1);
        tick;
        chk("t6_rxen", 32'(O_rx_en), 0);
        chk("t6_err", 32'(O_err), 1);
        chk("t6_done", 32'(O_done), 1);
        tick;
        chk("t6_err_pulse", 32'(O_err), 0);
        chk("t6_valid_cnt", 32'(valid_cnt), 5);
        I_rd_cnt = 4'd0;
        I_start = 1'b1;
        tick;
        chk("t6_restart", 32'(O_tx_en), 1);
        I_start = 1'b0;
        I_tx_done = 1'b1;
        tick;
        I_tx_done = 1'b0;
        tick;
        tick;
        tick;
        chk("t6_done2", 32'(O_done), 1);
        chk("t6_err2", 32'(O_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
